// File: rtl/xnor_conv_array.sv
// Binary (XNOR/popcount) convolution window: loads a KxK binary kernel row by row, then
// streams activation columns. Build with XNOR_CONV_THRESHOLD_EN to register a binarised out_bit.
module xnor_conv_array #(
    parameter int K          = 3,
    parameter int CIN        = 4,
    parameter int PSUM_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  weight_load,
    input  logic [K*CIN-1:0]      weight_in,
    output logic                  weights_ready,
    input  logic                  act_valid,
    input  logic                  act_first,
    input  logic [K*CIN-1:0]      act_in,
    output logic                  act_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PSUM_WIDTH-1:0] psum_out,
    input  logic [PSUM_WIDTH-1:0] thr_in,
    output logic                  out_bit,
    output logic [1:0]            state_dbg
);

    localparam int KC     = K * CIN;
    localparam int NBITS  = K * KC;
    localparam int ROW_W  = $clog2(K);
    localparam int FILL_W = $clog2(K + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;

    // Handshake: a column moves when act_valid && act_ready on a rising edge; a result
    // moves when out_valid && out_ready. act_ready never depends on act_valid.

    logic [1:0]            state;
    logic [ROW_W-1:0]      row_cnt;
    logic [FILL_W-1:0]     fill_cnt;
    logic [FILL_W-1:0]     fill_next;
    logic [NBITS-1:0]      weights;
    logic [NBITS-1:0]      window;
    logic [NBITS-1:0]      window_next;
    logic [NBITS-1:0]      xnor_bits;
    logic [PSUM_WIDTH-1:0] psum_next;
    logic                  accept;
    logic                  load_result;

    assign state_dbg = state;
    assign act_ready = (state == S_COMPUTE) && !weight_load && (!out_valid || out_ready);
    assign accept    = act_valid && act_ready;

    // Window slot 0 holds the oldest column; a new column enters at the top slot.
    assign window_next = {act_in, window[NBITS-1:KC]};
    assign xnor_bits   = ~(window_next ^ weights);

    always_comb begin
        fill_next = fill_cnt;
        if (act_first) begin
            fill_next = FILL_W'(1);
        end else if (fill_cnt != FILL_W'(K)) begin
            fill_next = fill_cnt + FILL_W'(1);
        end
    end

    assign load_result = accept && (fill_next == FILL_W'(K));

    always_comb begin
        psum_next = '0;
        for (int i = 0; i < NBITS; i++) begin
            psum_next = psum_next + PSUM_WIDTH'(xnor_bits[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            row_cnt       <= '0;
            fill_cnt      <= '0;
            weights       <= '0;
            window        <= '0;
            weights_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (weight_load) begin
                        weights[KC-1:0] <= weight_in;
                        row_cnt         <= ROW_W'(1);
                        state           <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (weight_load) begin
                        weights[int'(row_cnt)*KC +: KC] <= weight_in;
                        if (row_cnt == ROW_W'(K - 1)) begin
                            row_cnt       <= '0;
                            weights_ready <= 1'b1;
                            state         <= S_COMPUTE;
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    // A reload wins over a column offered in the same cycle.
                    if (weight_load) begin
                        weights[KC-1:0] <= weight_in;
                        row_cnt         <= ROW_W'(1);
                        fill_cnt        <= '0;
                        weights_ready   <= 1'b0;
                        state           <= S_LOAD;
                    end else if (accept) begin
                        window   <= window_next;
                        fill_cnt <= fill_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The result register is independent of the FSM so a pending result survives a reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            psum_out  <= '0;
        end else if (load_result) begin
            out_valid <= 1'b1;
            psum_out  <= psum_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef XNOR_CONV_THRESHOLD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_bit <= 1'b0;
        end else if (load_result) begin
            out_bit <= (psum_next >= thr_in);
        end
    end
`else
    logic unused_thr;
    assign unused_thr = ^thr_in;
    assign out_bit    = 1'b0;
`endif

endmodule

// File: tb/tb_xnor_conv_array.sv
// Directed bench for xnor_conv_array (K=3, CIN=4): weight loading, streaming, backpressure,
// row restart, reload priority, threshold bit and asynchronous reset.
module tb_xnor_conv_array;

    localparam int K  = 3;
    localparam int CIN = 4;
    localparam int KC = K * CIN;
    localparam int PW = 8;
    localparam logic [KC-1:0] ONES  = 12'hFFF;
    localparam logic [KC-1:0] ZEROS = 12'h000;
`ifdef XNOR_CONV_THRESHOLD_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          weight_load;
    logic [KC-1:0] weight_in;
    logic          weights_ready;
    logic          act_valid;
    logic          act_first;
    logic [KC-1:0] act_in;
    logic          act_ready;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] psum_out;
    logic [PW-1:0] thr_in;
    logic          out_bit;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PW-1:0] exp_q[$];

    xnor_conv_array #(.K(K), .CIN(CIN), .PSUM_WIDTH(PW)) dut (
        .clk(clk), .rst(rst),
        .weight_load(weight_load), .weight_in(weight_in), .weights_ready(weights_ready),
        .act_valid(act_valid), .act_first(act_first), .act_in(act_in), .act_ready(act_ready),
        .out_valid(out_valid), .out_ready(out_ready), .psum_out(psum_out),
        .thr_in(thr_in), .out_bit(out_bit), .state_dbg(state_dbg)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_col(input logic [KC-1:0] a, input logic first);
        act_valid = 1'b1;
        act_in    = a;
        act_first = first;
        tick();
        act_valid = 1'b0;
        act_first = 1'b0;
    endtask

    task automatic load_weights(input logic [KC-1:0] row);
        for (int r = 0; r < K; r++) begin
            weight_load = 1'b1;
            weight_in   = row;
            tick();
        end
        weight_load = 1'b0;
        weight_in   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; weight_load = 1'b0; weight_in = '0; act_valid = 1'b0; act_first = 1'b0;
        act_in = '0; out_ready = 1'b1; thr_in = '0;
        tick();
        tick();
        n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        n_checks++; if (weights_ready !== 1'b0) begin n_fail++; $display("FAIL reset_weights_ready: got %b expected 0", weights_ready); end
        act_valid = 1'b1;
        #1;
        n_checks++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL reset_act_ready: got %b expected 0", act_ready); end
        act_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (psum_out !== 8'd0) begin n_fail++; $display("FAIL reset_psum: got %0d expected 0", psum_out); end
        n_checks++; if (out_bit !== 1'b0) begin n_fail++; $display("FAIL reset_out_bit: got %b expected 0", out_bit); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_weight_load();
        weight_load = 1'b1;
        weight_in   = ONES;
        tick();
        n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL load_row0_state: got %0d expected 1", state_dbg); end
        weight_load = 1'b0;
        tick();
        n_checks++; if (state_dbg !== 2'd1 || weights_ready !== 1'b0) begin n_fail++; $display("FAIL load_hold: state %0d ready %b expected 1 0", state_dbg, weights_ready); end
        weight_load = 1'b1;
        tick();
        n_checks++; if (weights_ready !== 1'b0) begin n_fail++; $display("FAIL load_row1_ready: got %b expected 0", weights_ready); end
        tick();
        weight_load = 1'b0;
        n_checks++; if (weights_ready !== 1'b1 || state_dbg !== 2'd2) begin n_fail++; $display("FAIL load_done: ready %b state %0d expected 1 2", weights_ready, state_dbg); end
    endtask

    task automatic test_all_ones();
        out_ready = 1'b1;
        act_valid = 1'b1;
        #1;
        n_checks++; if (act_ready !== 1'b1) begin n_fail++; $display("FAIL ones_act_ready: got %b expected 1", act_ready); end
        send_col(ONES, 1'b1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ones_col1_valid: got %b expected 0", out_valid); end
        send_col(ONES, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ones_col2_valid: got %b expected 0", out_valid); end
        send_col(ONES, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd36) begin n_fail++; $display("FAIL ones_result: valid %b psum %0d expected 1 36", out_valid, psum_out); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ones_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_zeros_then_one();
        send_col(ZEROS, 1'b1);
        send_col(ZEROS, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zeros_col2_valid: got %b expected 0", out_valid); end
        send_col(ZEROS, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd0) begin n_fail++; $display("FAIL zeros_result: valid %b psum %0d expected 1 0", out_valid, psum_out); end
        send_col(ONES, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd12) begin n_fail++; $display("FAIL zeros_then_one: valid %b psum %0d expected 1 12", out_valid, psum_out); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zeros_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_col(ONES, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd24) begin n_fail++; $display("FAIL bp_result: valid %b psum %0d expected 1 24", out_valid, psum_out); end
        act_valid = 1'b1;
        act_in    = ONES;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL bp_act_ready[%0d]: got %b expected 0", i, act_ready); end
            n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd24) begin n_fail++; $display("FAIL bp_hold[%0d]: valid %b psum %0d expected 1 24", i, out_valid, psum_out); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (act_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", act_ready); end
        tick();
        act_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd36) begin n_fail++; $display("FAIL bp_next: valid %b psum %0d expected 1 36", out_valid, psum_out); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_act_first();
        send_col(ZEROS, 1'b1);
        send_col(ZEROS, 1'b0);
        send_col(ZEROS, 1'b0);
        send_col(ZEROS, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd0) begin n_fail++; $display("FAIL first_col4: valid %b psum %0d expected 1 0", out_valid, psum_out); end
        send_col(ONES, 1'b1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_new1: got %b expected 0", out_valid); end
        send_col(ONES, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_new2: got %b expected 0", out_valid); end
        send_col(ONES, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd36) begin n_fail++; $display("FAIL first_new3: valid %b psum %0d expected 1 36", out_valid, psum_out); end
        tick();
    endtask

    task automatic test_threshold();
        logic [PW-1:0] exp_psum [5] = '{8'd12, 8'd24, 8'd36, 8'd36, 8'd36};
        logic [PW-1:0] thr_tab  [5] = '{8'd20, 8'd20, 8'd20, 8'd36, 8'd37};
        logic          exp_bit;
        send_col(ZEROS, 1'b1);
        send_col(ZEROS, 1'b0);
        for (int i = 0; i < 5; i++) begin
            thr_in = thr_tab[i];
            send_col(ONES, 1'b0);
            exp_bit = THR_EN && (exp_psum[i] >= thr_tab[i]);
            n_checks++; if (out_valid !== 1'b1 || psum_out !== exp_psum[i]) begin n_fail++; $display("FAIL thr_psum[%0d]: valid %b psum %0d expected 1 %0d", i, out_valid, psum_out, exp_psum[i]); end
            n_checks++; if (out_bit !== exp_bit) begin n_fail++; $display("FAIL thr_bit[%0d]: got %b expected %b", i, out_bit, exp_bit); end
        end
        tick();
    endtask

    task automatic test_pattern();
        logic [KC-1:0] cols [6] = '{12'hF0F, 12'hF0F, 12'hF0F, 12'h0FF, 12'h000, 12'hFFF};
        logic [PW-1:0] got;
        load_weights(12'hF0F);
        n_checks++; if (weights_ready !== 1'b1) begin n_fail++; $display("FAIL pat_reload_ready: got %b expected 1", weights_ready); end
        // Per-column matches against F0F rows: F0F=12, 0FF=4, 000=4, FFF=8 (times K rows summed per slot).
        exp_q.push_back(8'd36);
        exp_q.push_back(8'd28);
        exp_q.push_back(8'd20);
        exp_q.push_back(8'd16);
        for (int i = 0; i < 6; i++) begin
            send_col(cols[i], i == 0);
            n_checks++; if (out_valid !== (i >= 2)) begin n_fail++; $display("FAIL pat_valid[%0d]: got %b expected %b", i, out_valid, (i >= 2)); end
            if (out_valid === 1'b1 && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                n_checks++; if (psum_out !== got) begin n_fail++; $display("FAIL pat_psum[%0d]: got %0d expected %0d", i, psum_out, got); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pat_queue: %0d results missing, expected 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_weight_load_priority();
        out_ready = 1'b0;
        send_col(12'hF0F, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd24) begin n_fail++; $display("FAIL prio_pending: valid %b psum %0d expected 1 24", out_valid, psum_out); end
        weight_load = 1'b1; weight_in = ONES; act_valid = 1'b1; act_in = ZEROS;
        #1;
        n_checks++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL prio_act_ready: got %b expected 0", act_ready); end
        tick();
        weight_load = 1'b0; act_valid = 1'b0;
        n_checks++; if (state_dbg !== 2'd1 || weights_ready !== 1'b0) begin n_fail++; $display("FAIL prio_state: state %0d ready %b expected 1 0", state_dbg, weights_ready); end
        n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd24) begin n_fail++; $display("FAIL prio_held: valid %b psum %0d expected 1 24", out_valid, psum_out); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || state_dbg !== 2'd1) begin n_fail++; $display("FAIL prio_taken: valid %b state %0d expected 0 1", out_valid, state_dbg); end
        weight_load = 1'b1;
        tick();
        tick();
        weight_load = 1'b0;
        n_checks++; if (weights_ready !== 1'b1) begin n_fail++; $display("FAIL prio_reload: got %b expected 1", weights_ready); end
        send_col(ONES, 1'b0);
        send_col(ONES, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL prio_fill_cleared: got %b expected 0", out_valid); end
        send_col(ONES, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd36) begin n_fail++; $display("FAIL prio_result: valid %b psum %0d expected 1 36", out_valid, psum_out); end
        tick();
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b0;
        thr_in    = 8'd20;
        send_col(ONES, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || psum_out !== 8'd36) begin n_fail++; $display("FAIL rst_stream_pending: valid %b psum %0d expected 1 36", out_valid, psum_out); end
        act_valid = 1'b1;
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || psum_out !== 8'd0 || out_bit !== 1'b0) begin n_fail++; $display("FAIL rst_stream_outputs: valid %b psum %0d bit %b expected 0 0 0", out_valid, psum_out, out_bit); end
        n_checks++; if (act_ready !== 1'b0 || weights_ready !== 1'b0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_stream_ctrl: act_ready %b ready %b state %0d expected 0 0 0", act_ready, weights_ready, state_dbg); end
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        n_checks++; if (act_ready !== 1'b0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_stream_after: act_ready %b state %0d expected 0 0", act_ready, state_dbg); end
        act_valid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        weight_load = 1'b1;
        weight_in   = ONES;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_load_state: got %0d expected 0", state_dbg); end
        tick();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (weights_ready !== 1'b0 || state_dbg !== 2'd1) begin n_fail++; $display("FAIL rst_load_partial: ready %b state %0d expected 0 1", weights_ready, state_dbg); end
        tick();
        weight_load = 1'b0;
        n_checks++; if (weights_ready !== 1'b1) begin n_fail++; $display("FAIL rst_load_full: got %b expected 1", weights_ready); end
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_all_ones();
        test_zeros_then_one();
        test_backpressure();
        test_act_first();
        test_threshold();
        test_pattern();
        test_weight_load_priority();
        test_reset_mid_stream();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xnor_conv_array.md
XNOR_CONV_ARRAY -- requirements
Module: xnor_conv_array

Interface
REQ-001 SHALL have parameter K, default 3, kernel height/width (2..7).
REQ-002 SHALL have parameter CIN, default 4, binary input channels per pixel (1..16).
REQ-003 SHALL have parameter PSUM_WIDTH, default 8, popcount width; it SHALL be at least clog2(K*K*CIN+1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state is on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port weight_load, input, 1, weight row strobe.
REQ-007 SHALL have port weight_in, input, K*CIN, one kernel row (column-major, channel LSB-first).
REQ-008 SHALL have port weights_ready, output, 1, all K rows loaded.
REQ-009 SHALL have port act_valid, input, 1, activation column offered.
REQ-010 SHALL have port act_first, input, 1, qualifies act_in as the first column of a new image row.
REQ-011 SHALL have port act_in, input, K*CIN, one activation column (K pixels x CIN bits).
REQ-012 SHALL have port act_ready, output, 1, column accepted when act_valid and act_ready are both high.
REQ-013 SHALL have port out_valid, output, 1, result held.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-015 SHALL have port psum_out, output, PSUM_WIDTH, unsigned XNOR popcount.
REQ-016 SHALL have port thr_in, input, PSUM_WIDTH, binarisation threshold.
REQ-017 SHALL have port out_bit, output, 1, binarised activation.

Function
REQ-018 SHALL implement states S_IDLE, S_LOAD and S_COMPUTE.
REQ-019 In S_IDLE, weight_load SHALL move the block to S_LOAD, capture row 0 and set the row counter to 1.
REQ-020 In S_LOAD, each weight_load cycle SHALL capture the next row; after row K-1 the block SHALL enter S_COMPUTE and assert weights_ready.
REQ-021 In S_LOAD, cycles without weight_load SHALL hold state; there is no timeout.
REQ-022 In S_COMPUTE, weight_load SHALL clear weights_ready and the window fill count, capture row 0 and re-enter S_LOAD; any pending output SHALL be held until taken.
REQ-023 act_ready SHALL equal (state==S_COMPUTE) AND NOT weight_load AND (NOT out_valid OR out_ready).
REQ-024 An accepted column SHALL shift into a K-column window register, oldest column discarded.
REQ-025 Window fill count (saturating at K) SHALL increment per accepted column; an accepted column with act_first SHALL set the count to 1.
REQ-026 When an accepted column brings the fill count to K (or it is already K), the next cycle SHALL present psum_out = popcount(XNOR(window, weights)) over K*K*CIN bits with out_valid=1.
REQ-027 Latency SHALL be exactly 1 cycle from the accepting edge to out_valid high.
REQ-028 out_valid SHALL clear on the out_ready handshake unless a new result loads on the same edge, in which case out_valid stays high with the new data.
REQ-029 psum_out and out_bit SHALL remain stable while out_valid=1 and out_ready=0.
REQ-030 weight_load in S_COMPUTE SHALL take priority over a simultaneous act_valid; that column SHALL NOT be accepted.

Reset
REQ-031 While rst=0: state=S_IDLE, weights, window, fill count and row counter =0, weights_ready=0, act_ready=0, out_valid=0, psum_out=0, out_bit=0.
REQ-032 Reset asserted mid-load or mid-stream SHALL discard all partial weights, window contents and pending output.

Configuration
REQ-033 Macro XNOR_CONV_THRESHOLD_EN, when defined, SHALL register out_bit = (popcount >= thr_in) alongside psum_out.
REQ-034 Without XNOR_CONV_THRESHOLD_EN, out_bit SHALL be constant 0, thr_in SHALL be ignored, and no comparator SHALL be built.

Verification
REQ-035 Scenario: K=3, CIN=4; load 3 all-ones rows; stream 3 all-ones columns -> weights_ready after row 3; one out_valid with psum_out=36.
REQ-036 Scenario: all-ones weights; stream columns of all zeros, then one all-ones column -> psum_out=0 at the third column, then 12.
REQ-037 Scenario: hold out_ready=0 for 5 cycles with a result pending -> act_ready=0; psum_out stable; the next column is accepted on the cycle out_ready rises.
REQ-038 Scenario: after 4 columns, send act_first with 2 more columns -> no out_valid until the third column of the new row.
REQ-039 Scenario: pulse weight_load and act_valid together in S_COMPUTE -> column not accepted; weights_ready=0; S_LOAD entered.
REQ-040 Scenario: with XNOR_CONV_THRESHOLD_EN, thr_in=20 -> out_bit=1 for psum 36 and 0 for psum 12; assert rst=0 mid-stream -> all outputs 0 next cycle.
